// File: rtl/alu_mul_seq_if.sv
// Request/response bundle between the core and the shift-add multiply sequencer.
// The core is the master: it raises start with operands and watches busy/done/result.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier (low WIDTH bits) that borrows the shared ALU
// for its additions; it holds the partial product and shifts operands but owns no adder.
module alu_mul_seq #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_mul_seq_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sig,
    input  logic [WIDTH-1:0] alu_result
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [2:0]      SIG_ADD  = 3'b010;
    localparam logic [2:0]      SIG_AND  = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next;
    logic             last_iter;
    logic             accept;

    // The ALU output depends on alu_a/alu_b, so these stay out of the FSM block.
    assign alu_a   = (state == RUN) ? acc   : '0;
    assign alu_b   = (state == RUN) ? mcand : '0;
    assign alu_sig = (state == RUN) ? SIG_ADD : SIG_AND;

    assign acc_next  = mplier[0] ? alu_result : acc;
    assign last_iter = (cnt == CNT_LAST) || (EARLY_EXIT && ((mplier >> 1) == '0));

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // result is only written on the final iteration, so it survives IDLE untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
                result_q <= acc_next;
            end
        end
    end
endmodule
